// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2^N active-low line decoder with direct decode and prescaled scan modes.
// Build option: define DECODER_BBM_EN for a break-before-make dead cycle on every line change.
module decoder_nx2n_scan #(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic [N-1:0]      sel,
  input  logic              load,
  output logic [0:(1<<N)-1] D,
  output logic [N-1:0]      scan_idx,
  output logic              wrap
);

  localparam int LINES = 1 << N;
  localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]    presc_r;
  logic [PW-1:0]    presc_s;
  logic             mode_r;
  logic [N-1:0]     idx_s;
  logic [0:LINES-1] d_s;
  logic             wrap_s;
  logic             step_s;
`ifdef DECODER_BBM_EN
  logic [N-1:0]     last_sel_r;
  logic [N-1:0]     last_sel_s;
`endif

  function automatic logic [0:LINES-1] decode_line(input logic [N-1:0] idx);
    logic [0:LINES-1] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

  // Next-state and next-output selection for both operating modes.
  always_comb begin
    d_s     = '1;
    idx_s   = scan_idx;
    presc_s = presc_r;
    wrap_s  = 1'b0;
    step_s  = (presc_r == PRESC_LAST);
    if (!mode) begin
      idx_s   = '0;
      presc_s = '0;
      if (enable) begin
        d_s = '1;
      end else begin
`ifdef DECODER_BBM_EN
        if (sel != last_sel_r) begin
          d_s = '1;
        end else begin
          d_s = decode_line(sel);
        end
`else
        d_s = decode_line(sel);
`endif
      end
    end else if (load) begin
      // load wins over both mode entry and a coincident step
      idx_s   = sel;
      presc_s = '0;
      if (enable) begin
        d_s = '1;
      end else begin
        d_s = decode_line(sel);
      end
    end else if (!mode_r) begin
      idx_s   = '0;
      presc_s = '0;
      if (enable) begin
        d_s = '1;
      end else begin
        d_s = decode_line('0);
      end
    end else if (enable) begin
      d_s = '1;
    end else begin
      if (step_s) begin
        idx_s   = scan_idx + 1'b1;
        presc_s = '0;
        wrap_s  = (scan_idx == '1);
      end else begin
        presc_s = presc_r + 1'b1;
      end
`ifdef DECODER_BBM_EN
      if (step_s) begin
        d_s = '1;
      end else begin
        d_s = decode_line(idx_s);
      end
`else
      d_s = decode_line(idx_s);
`endif
    end
`ifdef DECODER_BBM_EN
    if (mode) begin
      last_sel_s = idx_s;
    end else if (!enable) begin
      last_sel_s = sel;
    end else begin
      last_sel_s = last_sel_r;
    end
`endif
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      D          <= '1;
      scan_idx   <= '0;
      presc_r    <= '0;
      wrap       <= 1'b0;
      mode_r     <= 1'b0;
`ifdef DECODER_BBM_EN
      last_sel_r <= '0;
`endif
    end else begin
      D          <= d_s;
      scan_idx   <= idx_s;
      presc_r    <= presc_s;
      wrap       <= wrap_s;
      mode_r     <= mode;
`ifdef DECODER_BBM_EN
      last_sel_r <= last_sel_s;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Self-checking bench for decoder_nx2n_scan (N=2, SCAN_DIV=4) against a behavioural model.
module tb_decoder_nx2n_scan;

  localparam int N        = 2;
  localparam int SCAN_DIV = 4;
  localparam int LINES    = 4;
`ifdef DECODER_BBM_EN
  localparam bit BBM = 1'b1;
`else
  localparam bit BBM = 1'b0;
`endif

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b1;
  logic       mode   = 1'b0;
  logic       load   = 1'b0;
  logic [1:0] sel    = 2'd0;
  logic [0:3] D;
  logic [1:0] scan_idx;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  // reference model state: m_low is the low line, -1 when all lines are high
  int m_idx   = 0;
  int m_presc = 0;
  int m_low   = -1;
  int m_last  = 0;
  bit m_wrap  = 1'b0;
  bit m_prev  = 1'b0;

  always #5 clock = ~clock;

  decoder_nx2n_scan #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .sel(sel), .load(load), .D(D), .scan_idx(scan_idx), .wrap(wrap)
  );

  function automatic logic [0:3] lines(input int low);
    logic [0:3] v;
    for (int i = 0; i < LINES; i++) v[i] = (i == low) ? 1'b0 : 1'b1;
    return v;
  endfunction

  task automatic model_step();
    bit stepped;
    stepped = 1'b0;
    if (reset) begin
      m_idx = 0; m_presc = 0; m_low = -1; m_wrap = 1'b0; m_prev = 1'b0; m_last = 0;
    end else begin
      m_wrap = 1'b0;
      if (!mode) begin
        m_idx = 0; m_presc = 0;
        if (enable) m_low = -1;
        else begin
          m_low  = (BBM && int'(sel) != m_last) ? -1 : int'(sel);
          m_last = int'(sel);
        end
      end else begin
        if (load) begin
          m_idx = int'(sel); m_presc = 0;
        end else if (!m_prev) begin
          m_idx = 0; m_presc = 0;
        end else if (!enable) begin
          m_presc = m_presc + 1;
          if (m_presc == SCAN_DIV) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % LINES;
            m_wrap  = (m_idx == 0);
            stepped = 1'b1;
          end
        end
        if (enable || (BBM && stepped)) m_low = -1;
        else m_low = m_idx;
        m_last = m_idx;
      end
      m_prev = mode;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      enable = 1'($urandom); mode = 1'($urandom); load = 1'($urandom); sel = 2'($urandom);
      tick();
      if (D !== 4'b1111) begin errors++; $display("FAIL reset_D: got %b expected 1111", D); end
      checks++;
      if (scan_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", scan_idx); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b expected 0", wrap); end
      checks++;
    end
    load = 1'b0;
  endtask

  task automatic test_direct();
    reset = 1'b1; tick();
    reset = 1'b0; mode = 1'b0; enable = 1'b0; sel = 2'd2; tick();
    if (D !== lines(m_low)) begin errors++; $display("FAIL direct_sel2: got %b expected %b", D, lines(m_low)); end
    checks++;
`ifndef DECODER_BBM_EN
    if (D !== 4'b1101) begin errors++; $display("FAIL direct_sel2_const: got %b expected 1101", D); end
    checks++;
`endif
    enable = 1'b1; tick();
    if (D !== 4'b1111) begin errors++; $display("FAIL direct_disabled: got %b expected 1111", D); end
    checks++;
    sel = 2'd0; enable = 1'b0; tick();
    if (D !== lines(m_low)) begin errors++; $display("FAIL direct_sel0: got %b expected %b", D, lines(m_low)); end
    checks++;
`ifndef DECODER_BBM_EN
    if (D !== 4'b0111) begin errors++; $display("FAIL direct_sel0_const: got %b expected 0111", D); end
    checks++;
`endif
    for (int c = 0; c < 24; c++) begin
      sel = 2'($urandom); enable = ($urandom_range(0, 3) == 0); load = 1'($urandom);
      tick();
      if (D !== lines(m_low) || scan_idx !== 2'd0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL direct_rand: got D=%b idx=%0d wrap=%b expected D=%b idx=0 wrap=0", D, scan_idx, wrap, lines(m_low));
      end
      checks++;
    end
    load = 1'b0;
  endtask

  task automatic test_scan();
    int wraps;
    int low_cnt;
    reset = 1'b1; tick();
    reset = 1'b0; mode = 1'b1; enable = 1'b0; load = 1'b0;
    wraps = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (D !== lines(m_low) || scan_idx !== 2'(m_idx) || wrap !== m_wrap) begin
        errors++;
        $display("FAIL scan_model c=%0d: got D=%b idx=%0d wrap=%b expected D=%b idx=%0d wrap=%b",
                 c, D, scan_idx, wrap, lines(m_low), m_idx, m_wrap);
      end
      checks++;
`ifndef DECODER_BBM_EN
      if (D !== lines(((c - 1) / 4) % 4) || wrap !== (c == 17)) begin
        errors++;
        $display("FAIL scan_frame c=%0d: got D=%b wrap=%b expected D=%b wrap=%b",
                 c, D, wrap, lines(((c - 1) / 4) % 4), (c == 17));
      end
      checks++;
`endif
      if (wrap === 1'b1) wraps++;
    end
    if (wraps !== 1) begin errors++; $display("FAIL scan_wrap_count: got %0d expected 1", wraps); end
    checks++;

    reset = 1'b1; tick();
    reset = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    enable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (D !== 4'b1111 || scan_idx !== 2'd2) begin
        errors++; $display("FAIL scan_hold: got D=%b idx=%0d expected D=1111 idx=2", D, scan_idx);
      end
      checks++;
    end
    enable = 1'b0;
    low_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (D !== lines(m_low)) begin errors++; $display("FAIL scan_resume: got %b expected %b", D, lines(m_low)); end
      checks++;
      if (D[2] === 1'b0 && scan_idx === 2'd2) low_cnt++;
    end
    if (low_cnt !== 2) begin errors++; $display("FAIL scan_remaining: got %0d expected 2", low_cnt); end
    checks++;
  endtask

  task automatic test_load_vs_step();
    reset = 1'b1; tick();
    reset = 1'b0; mode = 1'b1; enable = 1'b0; load = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    if (scan_idx !== 2'd1) begin errors++; $display("FAIL load_pre_idx: got %0d expected 1", scan_idx); end
    checks++;
    load = 1'b1; sel = 2'd3; tick();
    load = 1'b0;
    if (scan_idx !== 2'd3 || D !== 4'b1110 || wrap !== 1'b0) begin
      errors++; $display("FAIL load_step: got idx=%0d D=%b wrap=%b expected idx=3 D=1110 wrap=0", scan_idx, D, wrap);
    end
    checks++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (scan_idx !== 2'd3 || D !== lines(m_low)) begin
        errors++; $display("FAIL load_dwell: got idx=%0d D=%b expected idx=3 D=%b", scan_idx, D, lines(m_low));
      end
      checks++;
    end
    tick();
    if (scan_idx !== 2'd0 || wrap !== 1'b1) begin
      errors++; $display("FAIL load_wrap: got idx=%0d wrap=%b expected idx=0 wrap=1", scan_idx, wrap);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; tick();
    reset = 1'b0; mode = 1'b1; enable = 1'b0; load = 1'b0;
    for (int c = 1; c <= 10; c++) tick();
    if (scan_idx !== 2'd2) begin errors++; $display("FAIL midreset_pre: got %0d expected 2", scan_idx); end
    checks++;
    reset = 1'b1; tick();
    if (D !== 4'b1111 || scan_idx !== 2'd0 || wrap !== 1'b0) begin
      errors++; $display("FAIL midreset_vals: got D=%b idx=%0d wrap=%b expected 1111 0 0", D, scan_idx, wrap);
    end
    checks++;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (D !== 4'b0111) begin errors++; $display("FAIL midreset_d0: got %b expected 0111", D); end
      checks++;
    end
    tick();
    if (scan_idx !== 2'd1 || D !== lines(m_low)) begin
      errors++; $display("FAIL midreset_next: got idx=%0d D=%b expected idx=1 D=%b", scan_idx, D, lines(m_low));
    end
    checks++;
  endtask

  task automatic test_random();
    reset = 1'b1; tick();
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      enable = ($urandom_range(0, 7) == 0);
      load   = ($urandom_range(0, 15) == 0);
      sel    = 2'($urandom);
      tick();
      if (D !== lines(m_low) || scan_idx !== 2'(m_idx) || wrap !== m_wrap) begin
        errors++;
        $display("FAIL random c=%0d: got D=%b idx=%0d wrap=%b expected D=%b idx=%0d wrap=%b",
                 c, D, scan_idx, wrap, lines(m_low), m_idx, m_wrap);
      end
      checks++;
    end
    reset = 1'b0; load = 1'b0;
  endtask

`ifdef DECODER_BBM_EN
  task automatic test_bbm();
    reset = 1'b1; tick();
    reset = 1'b0; mode = 1'b1; enable = 1'b0; load = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c >= 5) begin
        if (D !== ((((c - 5) % 4) == 0) ? 4'b1111 : lines(((c - 5) / 4 + 1) % 4))) begin
          errors++; $display("FAIL bbm_scan c=%0d: got %b", c, D);
        end
        checks++;
      end
    end
    mode = 1'b0; sel = 2'd0; tick(); tick();
    if (D !== 4'b0111) begin errors++; $display("FAIL bbm_direct_settle: got %b expected 0111", D); end
    checks++;
    sel = 2'd3; tick();
    if (D !== 4'b1111) begin errors++; $display("FAIL bbm_direct_dead: got %b expected 1111", D); end
    checks++;
    tick();
    if (D !== 4'b1110) begin errors++; $display("FAIL bbm_direct_new: got %b expected 1110", D); end
    checks++;
  endtask
`endif

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_load_vs_step();
    test_reset_mid();
    test_random();
`ifdef DECODER_BBM_EN
    test_bbm();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
